// File: rtl/dpmem_clr.sv
// dpmem_clr: single-clock true dual-port RAM with byte-lane writes, per-port
// write mode, optional output registers and a clear sequencer that fills the
// array with CLRVAL after every reset.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_CLEAR | sequencer writes CLRVAL to ram[cnt_q]; ports ignored, busy = 1
//   ST_READY | both ports serve accesses independently, busy = 0
//
// Write modes (MODEA / MODEB): 0 read-first, 1 write-first, 2 no-change.
// Same-address, same-lane writes from both ports resolve to port B.
// A port reading a word the other port writes in the same cycle sees the old word.

module dpmem_clr #(
    parameter int                 DEPTH   = 10,
    parameter int                 WIDTH   = 32,
    parameter int                 BYTEW   = 8,
    parameter int                 MODEA   = 0,
    parameter int                 MODEB   = 0,
    parameter int                 OUTREGA = 1,
    parameter int                 OUTREGB = 1,
    parameter logic [WIDTH-1:0]   CLRVAL  = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      busy,
    input  logic                      ena,
    input  logic [WIDTH/BYTEW-1:0]    wea,
    input  logic [DEPTH-1:0]          addra,
    input  logic [WIDTH-1:0]          dia,
    output logic [WIDTH-1:0]          doa,
    input  logic                      enb,
    input  logic [WIDTH/BYTEW-1:0]    web,
    input  logic [DEPTH-1:0]          addrb,
    input  logic [WIDTH-1:0]          dib,
    output logic [WIDTH-1:0]          dob
);

    localparam int NBYTE = WIDTH / BYTEW;
    localparam int NWORD = 2 ** DEPTH;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t             state_q, state_d;
    logic [DEPTH-1:0]   cnt_q, cnt_d;
    logic               clr_we;
    logic               ready;

    logic [WIDTH-1:0]   ram [0:NWORD-1];

    logic [WIDTH-1:0]   old_a, old_b;
    logic [WIDTH-1:0]   merge_a, merge_b;
    logic [NBYTE-1:0]   lane_we_a, lane_we_b;

    logic [WIDTH-1:0]   rd_a_q, rd_a_d;
    logic [WIDTH-1:0]   rd_b_q, rd_b_d;
    logic [WIDTH-1:0]   doa_q, doa_d;
    logic [WIDTH-1:0]   dob_q, dob_d;

    assign ready = (state_q == ST_READY);
    assign busy  = (state_q == ST_CLEAR);

    // Sequencer state and clear address register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: walk every address once, leave CLEAR on the last write.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + DEPTH'(1);
                if (cnt_q == {DEPTH{1'b1}}) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    assign old_a = ram[addra];
    assign old_b = ram[addrb];

    assign lane_we_a = (ready && ena) ? wea : '0;
    assign lane_we_b = (ready && enb) ? web : '0;

    // Write-first view of each port: its own written lanes over the old word.
    always_comb begin
        merge_a = old_a;
        merge_b = old_b;
        for (int i = 0; i < NBYTE; i++) begin
            if (wea[i]) merge_a[i*BYTEW +: BYTEW] = dia[i*BYTEW +: BYTEW];
            if (web[i]) merge_b[i*BYTEW +: BYTEW] = dib[i*BYTEW +: BYTEW];
        end
    end

    // Array update. Port B lanes are assigned after port A so B wins overlaps.
    // While rst is held the sequencer sits at address 0 and keeps rewriting
    // CLRVAL there, which is the value that word receives anyway.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            ram[cnt_q] <= CLRVAL;
        end else begin
            for (int i = 0; i < NBYTE; i++) begin
                if (lane_we_a[i]) ram[addra][i*BYTEW +: BYTEW] <= dia[i*BYTEW +: BYTEW];
                if (lane_we_b[i]) ram[addrb][i*BYTEW +: BYTEW] <= dib[i*BYTEW +: BYTEW];
            end
        end
    end

    // Read-stage next values per port mode; disabled ports hold.
    always_comb begin
        rd_a_d = rd_a_q;
        rd_b_d = rd_b_q;
        if (ready && ena) begin
            if (|wea) begin
                if (MODEA == 0)      rd_a_d = old_a;
                else if (MODEA == 1) rd_a_d = merge_a;
                else                 rd_a_d = rd_a_q;
            end else begin
                rd_a_d = old_a;
            end
        end
        if (ready && enb) begin
            if (|web) begin
                if (MODEB == 0)      rd_b_d = old_b;
                else if (MODEB == 1) rd_b_d = merge_b;
                else                 rd_b_d = rd_b_q;
            end else begin
                rd_b_d = old_b;
            end
        end
    end

    // Output registers advance only with their port enable.
    always_comb begin
        doa_d = doa_q;
        dob_d = dob_q;
        if (ready && ena) doa_d = rd_a_q;
        if (ready && enb) dob_d = rd_b_q;
    end

    // Read stages and output registers; cleared by reset, the array is not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
            doa_q  <= '0;
            dob_q  <= '0;
        end else begin
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
            doa_q  <= doa_d;
            dob_q  <= dob_d;
        end
    end

    assign doa = (OUTREGA != 0) ? doa_q : rd_a_q;
    assign dob = (OUTREGB != 0) ? dob_q : rd_b_q;

endmodule
